acc_csr: RTL and testbench

ACC_CSR -- requirements
Module: acc_csr

---
 rtl/acc_csr.sv | 246 ++++++++++++++++++++++++
 tb/tb_acc_csr.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_csr.sv
// AXI4-Lite register block for the accelerator core: CTRL, STATUS, IRQ_EN, VERSION
// and NPRM parameter registers, with sticky W1C status and a level interrupt.
module acc_csr #(
  parameter int unsigned NPRM         = 5,
  parameter int unsigned PRM_W        = 9,
  parameter bit          AUTO_CLR_RUN = 1'b1,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [31:0]           S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [31:0]           S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  input  logic                  busy,
  input  logic                  done_evt,
  input  logic                  err_evt,
  output logic                  matw,
  output logic                  run,
  output logic                  last,
  output logic                  start,
  output logic [NPRM*PRM_W-1:0] prm,
  output logic                  irq
);

  localparam logic [9:0] IDX_CTRL    = 10'd0;
  localparam logic [9:0] IDX_STATUS  = 10'd1;
  localparam logic [9:0] IDX_IRQ_EN  = 10'd2;
  localparam logic [9:0] IDX_VERSION = 10'd3;
  localparam logic [9:0] IDX_PRM0    = 10'd4;
  localparam logic [9:0] IDX_PRM_END = 10'(IDX_PRM0 + NPRM);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_W, S_WAIT_AW, S_BRESP, S_RFETCH, S_RRESP} state_t;

  state_t      state_q;
  logic [9:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [9:0]  raddr_q;
  logic        commit_pend_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  irq_en_q;

  logic [31:0] rd_data_c;
  logic [1:0]  rd_resp_c;
  logic [31:0] wmask_c;
  logic        commit_c;
  logic        ctrl_wr_c;
  logic        stat_wr_c;
  logic        ien_wr_c;
  logic        unused_c;

  assign unused_c = ^{S_AXI_AWADDR[31:12], S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[31:12], S_AXI_ARADDR[1:0]};

  function automatic logic is_prm(input logic [9:0] idx);
    return (idx >= IDX_PRM0) && (idx < IDX_PRM_END);
  endfunction

  function automatic logic [1:0] wr_resp(input logic [9:0] idx);
    return ((idx <= IDX_IRQ_EN) || is_prm(idx)) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Register commit happens once, on the edge that ends the first BRESP cycle.
  assign commit_c  = (state_q == S_BRESP) && commit_pend_q;
  assign ctrl_wr_c = commit_c && (waddr_q == IDX_CTRL)   && wstrb_q[0];
  assign stat_wr_c = commit_c && (waddr_q == IDX_STATUS) && wstrb_q[0];
  assign ien_wr_c  = commit_c && (waddr_q == IDX_IRQ_EN) && wstrb_q[0];
  assign wmask_c   = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (raddr_q)
      IDX_CTRL:    rd_data_c = {29'd0, last, run, matw};
      IDX_STATUS:  rd_data_c = {29'd0, err_q, done_q, busy};
      IDX_IRQ_EN:  rd_data_c = {30'd0, irq_en_q};
      IDX_VERSION: rd_data_c = VERSION;
      default: begin
        rd_resp_c = is_prm(raddr_q) ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned k = 0; k < NPRM; k++) begin
          if (raddr_q == 10'(IDX_PRM0 + k)) rd_data_c = 32'(prm[k*PRM_W +: PRM_W]);
        end
      end
    endcase
  end

  // Bus handshake FSM; READY/VALID outputs are registered alongside the state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      commit_pend_q <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      raddr_q       <= '0;
    end else begin
      commit_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            waddr_q       <= S_AXI_AWADDR[11:2];
            wdata_q       <= S_AXI_WDATA;
            wstrb_q       <= S_AXI_WSTRB;
            S_AXI_BRESP   <= wr_resp(S_AXI_AWADDR[11:2]);
            S_AXI_BVALID  <= 1'b1;
            commit_pend_q <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            state_q       <= S_BRESP;
          end else if (S_AXI_AWVALID) begin
            waddr_q       <= S_AXI_AWADDR[11:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            state_q       <= S_WAIT_W;
          end else if (S_AXI_WVALID) begin
            wdata_q       <= S_AXI_WDATA;
            wstrb_q       <= S_AXI_WSTRB;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            state_q       <= S_WAIT_AW;
          end else if (S_AXI_ARVALID) begin
            raddr_q       <= S_AXI_ARADDR[11:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            state_q       <= S_RFETCH;
          end
        end
        S_WAIT_W: begin
          if (S_AXI_WVALID) begin
            wdata_q       <= S_AXI_WDATA;
            wstrb_q       <= S_AXI_WSTRB;
            S_AXI_BRESP   <= wr_resp(waddr_q);
            S_AXI_BVALID  <= 1'b1;
            commit_pend_q <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            state_q       <= S_BRESP;
          end
        end
        S_WAIT_AW: begin
          if (S_AXI_AWVALID) begin
            waddr_q       <= S_AXI_AWADDR[11:2];
            S_AXI_BRESP   <= wr_resp(S_AXI_AWADDR[11:2]);
            S_AXI_BVALID  <= 1'b1;
            commit_pend_q <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
            state_q       <= S_BRESP;
          end
        end
        S_BRESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_RFETCH: begin
          S_AXI_RDATA  <= rd_data_c;
          S_AXI_RRESP  <= rd_resp_c;
          S_AXI_RVALID <= 1'b1;
          state_q      <= S_RRESP;
        end
        S_RRESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY  <= 1'b1;
          S_AXI_ARREADY <= 1'b1;
          S_AXI_BVALID  <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  // CSR contents: a CTRL write beats the run auto-clear, an event beats its W1C.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      matw     <= 1'b0;
      run      <= 1'b0;
      last     <= 1'b0;
      start    <= 1'b0;
      irq_en_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq      <= 1'b0;
      prm      <= '0;
    end else begin
      start <= ctrl_wr_c && wdata_q[3];
      if (ctrl_wr_c) begin
        matw <= wdata_q[0];
        run  <= wdata_q[1];
        last <= wdata_q[2];
      end else if (AUTO_CLR_RUN && done_evt) begin
        run <= 1'b0;
      end
      if (ien_wr_c) irq_en_q <= wdata_q[1:0];
      done_q <= done_evt || (done_q && !(stat_wr_c && wdata_q[1]));
      err_q  <= err_evt  || (err_q  && !(stat_wr_c && wdata_q[2]));
      irq    <= |({err_q, done_q} & irq_en_q);
      for (int unsigned k = 0; k < NPRM; k++) begin
        if (commit_c && (waddr_q == 10'(IDX_PRM0 + k))) begin
          prm[k*PRM_W +: PRM_W] <=
            PRM_W'((32'(prm[k*PRM_W +: PRM_W]) & ~wmask_c) | (wdata_q & wmask_c));
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_csr.sv
// Randomized self-checking bench for acc_csr against a register-level reference model.
module tb_acc_csr;

  localparam int unsigned NPRM     = 5;
  localparam int unsigned PRM_W    = 9;
  localparam logic [31:0] VER      = 32'h0002_0000;
  localparam logic [31:0] PRM_MASK = (32'd1 << PRM_W) - 32'd1;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [31:0]           awaddr = '0;
  logic                  awvalid = 1'b0;
  logic                  awready;
  logic [31:0]           wdata = '0;
  logic [3:0]            wstrb = '0;
  logic                  wvalid = 1'b0;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready = 1'b0;
  logic [31:0]           araddr = '0;
  logic                  arvalid = 1'b0;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready = 1'b0;
  logic                  busy = 1'b0;
  logic                  done_evt = 1'b0;
  logic                  err_evt = 1'b0;
  logic                  matw, run, last, start, irq;
  logic [NPRM*PRM_W-1:0] prm;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_matw, m_run, m_last, m_done, m_err;
  bit   [1:0]  m_ien;
  logic [31:0] m_prm [NPRM];

  always #5 aclk = ~aclk;

  acc_csr #(.NPRM(NPRM), .PRM_W(PRM_W), .AUTO_CLR_RUN(1'b1), .VERSION(VER)) dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy), .done_evt(done_evt), .err_evt(err_evt),
    .matw(matw), .run(run), .last(last), .start(start), .prm(prm), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_prm_idx(input int idx);
    return (idx >= 4) && (idx < 4 + int'(NPRM));
  endfunction

  function automatic bit mapped_wr(input logic [31:0] a);
    int idx;
    idx = int'(a[11:2]);
    return (idx <= 2) || is_prm_idx(idx);
  endfunction

  function automatic bit mapped_rd(input logic [31:0] a);
    int idx;
    idx = int'(a[11:2]);
    return (idx <= 3) || is_prm_idx(idx);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[11:2]);
    if (idx == 0) return {29'd0, m_last, m_run, m_matw};
    if (idx == 1) return {29'd0, m_err, m_done, busy};
    if (idx == 2) return {30'd0, m_ien};
    if (idx == 3) return VER;
    if (is_prm_idx(idx)) return m_prm[idx-4];
    return 32'd0;
  endfunction

  function automatic bit model_irq();
    return (m_err && m_ien[1]) || (m_done && m_ien[0]);
  endfunction

  task automatic model_reset();
    m_matw = 0; m_run = 0; m_last = 0; m_done = 0; m_err = 0; m_ien = 2'b00;
    for (int k = 0; k < NPRM; k++) m_prm[k] = 32'd0;
  endtask

  // Apply one committed write plus any {err,done} event landing in the commit cycle.
  task automatic model_commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] ev, output bit st);
    int idx;
    bit ctrl_w, clr_d, clr_e;
    logic [31:0] v;
    idx    = int'(a[11:2]);
    ctrl_w = (idx == 0) && s[0];
    clr_d  = (idx == 1) && s[0] && d[1];
    clr_e  = (idx == 1) && s[0] && d[2];
    st     = ctrl_w && d[3];
    if (ctrl_w) begin
      m_matw = d[0]; m_run = d[1]; m_last = d[2];
    end else if (ev[0]) begin
      m_run = 0;
    end
    m_done = ev[0] || (m_done && !clr_d);
    m_err  = ev[1] || (m_err && !clr_e);
    if (idx == 2 && s[0]) m_ien = d[1:0];
    if (is_prm_idx(idx)) begin
      v = m_prm[idx-4];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      m_prm[idx-4] = v & PRM_MASK;
    end
  endtask

  task automatic check_regs();
    check_eq("matw", 32'(matw), 32'(m_matw));
    check_eq("run", 32'(run), 32'(m_run));
    check_eq("last", 32'(last), 32'(m_last));
    for (int k = 0; k < NPRM; k++) check_eq("prm", 32'(prm[k*PRM_W +: PRM_W]), m_prm[k]);
  endtask

  task automatic check_reset_state();
    check_eq("rst_awready", 32'(awready), 32'd1);
    check_eq("rst_wready", 32'(wready), 32'd1);
    check_eq("rst_arready", 32'(arready), 32'd1);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_resp", 32'({bresp, rresp}), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_ctrl", 32'({start, last, run, matw}), 32'd0);
    check_eq("rst_prm", 32'(|prm), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    model_reset();
    @(negedge aclk);
  endtask

  // lead>0: W leads AW by lead cycles; lead<0: AW leads W; ev lands in the commit cycle.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly, input logic [1:0] ev);
    bit exp_st;
    int st_cnt;
    logic [1:0] exp_resp;
    st_cnt   = 0;
    exp_resp = mapped_wr(a) ? 2'b00 : 2'b10;
    awaddr = a; wdata = d; wstrb = s;
    if (lead == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (lead > 0) begin
      wvalid = 1'b1;
      @(negedge aclk);
      wvalid = 1'b0;
      repeat (lead - 1) @(negedge aclk);
      awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
    end else begin
      awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      repeat (-lead - 1) @(negedge aclk);
      wvalid = 1'b1;
      @(negedge aclk);
      wvalid = 1'b0;
    end
    model_commit(a, d, s, ev, exp_st);
    for (int t = 0; t <= bdly; t++) begin
      check_eq("bvalid", 32'(bvalid), 32'd1);
      if (t == 0) begin
        check_eq("bresp", 32'(bresp), 32'(exp_resp));
        {err_evt, done_evt} = ev;
      end
      bready = (t == bdly);
      @(negedge aclk);
      {err_evt, done_evt} = 2'b00;
      st_cnt += int'(start);
      if (t == 0) begin
        check_eq("start_pulse", 32'(start), 32'(exp_st));
        check_regs();
      end
    end
    bready = 1'b0;
    check_eq("bvalid_drop", 32'(bvalid), 32'd0);
    @(negedge aclk);
    st_cnt += int'(start);
    check_eq("start_once", 32'(st_cnt), 32'(exp_st));
    check_eq("irq_wr", 32'(irq), 32'(model_irq()));
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = model_read(a);
    exp_r = mapped_rd(a) ? 2'b00 : 2'b10;
    check_eq("arready", 32'(arready), 32'd1);
    araddr = a; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("rvalid_early", 32'(rvalid), 32'd0);
    @(negedge aclk);
    for (int t = 0; t <= rdly; t++) begin
      check_eq("rvalid", 32'(rvalid), 32'd1);
      check_eq("rdata", rdata, exp_d);
      check_eq("rresp", 32'(rresp), 32'(exp_r));
      rready = (t == rdly);
      @(negedge aclk);
    end
    rready = 1'b0;
    check_eq("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic pulse_evt(input logic [1:0] ev);
    {err_evt, done_evt} = ev;
    @(negedge aclk);
    {err_evt, done_evt} = 2'b00;
    m_done = m_done || ev[0];
    m_err  = m_err || ev[1];
    if (ev[0]) m_run = 0;
    check_regs();
    @(negedge aclk);
    check_eq("irq_evt", 32'(irq), 32'(model_irq()));
  endtask

  initial begin
    logic [31:0] a;
    bit st;
    model_reset();
    repeat (2) @(negedge aclk);
    do_reset();

    // Basic PRM write, latency and width truncation
    axi_write(32'h010, 32'h0000_01FF, 4'hF, 0, 0, 2'b00);
    axi_read(32'h010, 0);
    axi_write(32'h014, 32'hFFFF_FFFF, 4'h2, 0, 1, 2'b00);
    axi_read(32'h014, 2);

    // W leads AW by two cycles, BREADY stalled, start pulse only
    axi_write(32'h000, 32'h0000_0008, 4'h1, 2, 5, 2'b00);
    axi_read(32'h000, 0);

    // Sticky done, set beating W1C, then W1C alone dropping irq
    axi_write(32'h008, 32'h0000_0001, 4'h1, -1, 0, 2'b00);
    pulse_evt(2'b01);
    check_eq("irq_done", 32'(irq), 32'd1);
    axi_read(32'h004, 0);
    check_eq("status_done", rdata, 32'h2);
    axi_write(32'h004, 32'h0000_0002, 4'h1, 0, 0, 2'b01);
    axi_read(32'h004, 1);
    axi_write(32'h004, 32'h0000_0002, 4'h1, 0, 0, 2'b00);
    check_eq("irq_cleared", 32'(irq), 32'd0);

    // Run auto-clear on done_evt
    axi_write(32'h000, 32'h0000_0002, 4'h1, 0, 0, 2'b00);
    pulse_evt(2'b01);
    axi_read(32'h000, 0);
    check_eq("run_autoclr", rdata, 32'h0);

    // Unmapped read, VERSION write rejected
    axi_read(32'h0FC, 0);
    axi_write(32'h00C, 32'h1234_5678, 4'hF, 0, 0, 2'b00);
    axi_read(32'h00C, 0);
    check_eq("version", rdata, VER);

    // Write wins over a simultaneous read; reset aborts the pending read data phase
    awaddr = 32'h018; wdata = 32'h0A5; wstrb = 4'hF; araddr = 32'h018;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    model_commit(32'h018, 32'h0A5, 4'hF, 2'b00, st);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("arb_bvalid", 32'(bvalid), 32'd1);
    check_eq("arb_arready", 32'(arready), 32'd0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check_eq("arb_bdone", 32'(bvalid), 32'd0);
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("arb_rvalid_early", 32'(rvalid), 32'd0);
    @(negedge aclk);
    check_eq("arb_rvalid", 32'(rvalid), 32'd1);
    check_eq("arb_rdata", rdata, model_read(32'h018));
    aresetn = 1'b0;
    @(negedge aclk);
    check_eq("rst_rrresp_rvalid", 32'(rvalid), 32'd0);
    check_reset_state();
    aresetn = 1'b1;
    model_reset();
    repeat (2) @(negedge aclk);
    check_eq("post_rst_valid", 32'({bvalid, rvalid}), 32'd0);

    // Reset during the commit cycle: no response surfaces afterwards
    awaddr = 32'h014; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("abort_bvalid", 32'(bvalid), 32'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    model_reset();
    repeat (2) @(negedge aclk);
    check_eq("abort_no_bvalid", 32'(bvalid), 32'd0);
    check_regs();

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int op;
      op   = int'($urandom_range(0, 9));
      busy = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, 11)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      if (op <= 4) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2,
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end else if (op <= 7) begin
        axi_read(a, int'($urandom_range(0, 3)));
      end else begin
        pulse_evt(2'($urandom_range(1, 3)));
      end
    end
    for (int r = 0; r < 10; r++) axi_read(32'(r) << 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
